// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the req/ack responder.
// Holds the FSM state encoding and the timer sizing helper.
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } req_ack_state_e;

    localparam int unsigned REQ_ACK_DELAY   = 4;
    localparam int unsigned REQ_ACK_MIN_GAP = 8;

    // The timer must be able to hold MIN_GAP itself for the final compare.
    function automatic int unsigned timer_width(input int unsigned min_gap);
        return $clog2(min_gap + 1);
    endfunction

endpackage : req_ack_pkg

// File: rtl/req_ack_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module req_ack_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : req_ack_sat_counter

// File: rtl/req_ack_responder.sv
// Responder side of the single-pulse req/ack handshake: acks each accepted req
// after ACK_DELAY cycles and flags reqs arriving inside MIN_GAP. REQ_ACK_STATS_EN enables counters.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int unsigned ACK_DELAY = REQ_ACK_DELAY,
    parameter int unsigned MIN_GAP   = REQ_ACK_MIN_GAP,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             ack,
    output logic             busy,
    output logic             err_early,
    output logic [CNT_W-1:0] reqs_seen,
    output logic [CNT_W-1:0] acks_seen
);

    localparam int unsigned TW = timer_width(MIN_GAP);
    localparam logic [TW-1:0] ACK_T = TW'(ACK_DELAY);
    localparam logic [TW-1:0] GAP_T = TW'(MIN_GAP);

    generate
        if ((ACK_DELAY < 1) || (ACK_DELAY >= MIN_GAP) || (CNT_W < 1)) begin : g_bad_params
            $error("req_ack_responder: need 1 <= ACK_DELAY < MIN_GAP and CNT_W >= 1");
        end
    endgenerate

    req_ack_state_e  state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_inc;

    assign timer_inc = timer + TW'(1);

    // Timer counts cycles since the accepted req; ack and busy are set from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            err_early <= 1'b0;
        end else begin
            ack       <= 1'b0;
            err_early <= req && (state != IDLE);
            case (state)
                IDLE: begin
                    if (req) begin
                        timer <= TW'(1);
                        busy  <= 1'b1;
                        if (ACK_DELAY == 1) begin
                            state <= ACK;
                            ack   <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    timer <= timer_inc;
                    if (timer_inc == ACK_T) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end
                end
                ACK, GAP: begin
                    if (timer_inc == GAP_T) begin
                        state <= IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else begin
                        state <= GAP;
                        timer <= timer_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REQ_ACK_STATS_EN
    logic accept;

    assign accept = req && (state == IDLE);

    req_ack_sat_counter #(.W(CNT_W)) u_reqs_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (reqs_seen)
    );

    // ack is already a one-cycle pulse, so it counts each ack cycle exactly once.
    req_ack_sat_counter #(.W(CNT_W)) u_acks_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ack),
        .count (acks_seen)
    );
`else
    assign reqs_seen = '0;
    assign acks_seen = '0;
`endif

endmodule : req_ack_responder
